slave_port: RTL and testbench

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port.sv | 181 ++++++++++++++++++
 tb/tb_slave_port.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port.sv
// Serial-bus slave port: bit-serial address/burst/data in, bit-serial read data out,
// backed by a small word memory that survives reset.
`timescale 1ns/1ps
module slave_port #(
   parameter int ADDR_LEN     = 12,
   parameter int DATA_LEN     = 8,
   parameter int BURST_LEN    = 12,
   parameter int MEM_ADDR_LEN = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic slave_select,
   input  logic master_valid,
   input  logic write_en,
   input  logic read_en,
   input  logic rx_address,
   input  logic rx_burst_number,
   input  logic rx_data,
   input  logic master_ready,
   output logic slave_ready,
   output logic slave_valid,
   output logic tx_data,
   output logic done
);

   localparam int CMAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      RWAIT,
      RDATA,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    is_rd_q, is_rd_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [MEM_ADDR_LEN-1:0] idx_q, idx_d;
   logic [BURST_LEN-1:0]    burst_q, burst_d;
   logic [BURST_LEN-1:0]    wcnt_q, wcnt_d;
   logic [DATA_LEN-1:0]     shift_q, shift_d;

   logic [DATA_LEN-1:0]     mem [2**MEM_ADDR_LEN];
   logic                    mem_we;
   logic [DATA_LEN-1:0]     mem_wdata;

   logic                    start;
   logic                    last_word;
   logic [MEM_ADDR_LEN-1:0] idx_sh;
   logic [BURST_LEN-1:0]    burst_sh;
   logic [DATA_LEN-1:0]     shift_in;

   assign start     = master_valid & slave_select & (write_en ^ read_en);
   assign last_word = (wcnt_q == burst_q);

   // LSB-first shift-in; only the low index bits are ever kept, so upper
   // address bits drop out naturally
   assign idx_sh    = MEM_ADDR_LEN'({rx_address, idx_q} >> 1);
   assign burst_sh  = BURST_LEN'({rx_burst_number, burst_q} >> 1);
   assign shift_in  = DATA_LEN'({rx_data, shift_q} >> 1);
   assign mem_wdata = shift_in;

   always_comb begin
      state_d = state_q;
      is_rd_d = is_rd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      burst_d = burst_q;
      wcnt_d  = wcnt_q;
      shift_d = shift_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ADDR;
               is_rd_d = read_en;
               cnt_d   = CW'(1);
               idx_d   = idx_sh;
               burst_d = burst_sh;
               wcnt_d  = '0;
               shift_d = '0;
            end
         end
         ADDR: begin
            if (!slave_select) begin
               state_d = IDLE;
            end else if (master_valid) begin
               if (cnt_q < CW'(MEM_ADDR_LEN)) idx_d = idx_sh;
               if (cnt_q < CW'(BURST_LEN)) burst_d = burst_sh;
               if (cnt_q == CW'(ADDR_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = is_rd_q ? RWAIT : WDATA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WDATA: begin
            if (!slave_select) begin
               state_d = IDLE;
            end else if (master_valid) begin
               shift_d = shift_in;
               if (cnt_q == CW'(DATA_LEN - 1)) begin
                  mem_we = reset;
                  cnt_d  = '0;
                  idx_d  = idx_q + MEM_ADDR_LEN'(1);
                  if (last_word) state_d = DONE;
                  else wcnt_d = wcnt_q + BURST_LEN'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         RWAIT: begin
            if (!slave_select) begin
               state_d = IDLE;
            end else begin
               shift_d = mem[idx_q];
               if (master_ready) begin
                  state_d = RDATA;
                  cnt_d   = '0;
               end
            end
         end
         RDATA: begin
            if (!slave_select) begin
               state_d = IDLE;
            end else begin
               shift_d = shift_q >> 1;
               if (cnt_q == CW'(DATA_LEN - 1)) begin
                  cnt_d = '0;
                  idx_d = idx_q + MEM_ADDR_LEN'(1);
                  if (last_word) begin
                     state_d = DONE;
                  end else begin
                     state_d = RWAIT;
                     wcnt_d  = wcnt_q + BURST_LEN'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         is_rd_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         burst_q <= '0;
         wcnt_q  <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         is_rd_q <= is_rd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         burst_q <= burst_d;
         wcnt_q  <= wcnt_d;
         shift_q <= shift_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= mem_wdata;
   end

   assign slave_ready = (state_q == IDLE) || (state_q == WDATA);
   assign slave_valid = (state_q == RDATA);
   assign tx_data     = (state_q == RDATA) & shift_q[0];
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: transaction-level expectations checked
// against the DUT outputs on every falling edge.
`timescale 1ns/1ps
module tb_slave_port;

   logic clk = 1'b0;
   logic reset;
   logic slave_select;
   logic master_valid;
   logic write_en;
   logic read_en;
   logic rx_address;
   logic rx_burst_number;
   logic rx_data;
   logic master_ready;
   logic slave_ready;
   logic slave_valid;
   logic tx_data;
   logic done;

   always #5 clk = ~clk;

   slave_port dut (
      .clk             (clk),
      .reset           (reset),
      .slave_select    (slave_select),
      .master_valid    (master_valid),
      .write_en        (write_en),
      .read_en         (read_en),
      .rx_address      (rx_address),
      .rx_burst_number (rx_burst_number),
      .rx_data         (rx_data),
      .master_ready    (master_ready),
      .slave_ready     (slave_ready),
      .slave_valid     (slave_valid),
      .tx_data         (tx_data),
      .done            (done)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;
   logic e_ready, e_valid, e_tx, e_done;
   logic [7:0] model [64];
   logic [7:0] wq [8];
   bit rd_bits [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("slave_ready", 32'(slave_ready), 32'(e_ready));
         chk("slave_valid", 32'(slave_valid), 32'(e_valid));
         chk("tx_data", 32'(tx_data), 32'(e_tx));
         chk("done", 32'(done), 32'(e_done));
         if (slave_valid === 1'b1) rd_bits.push_back(tx_data);
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic expect_o(input logic r, input logic v, input logic t,
                           input logic d);
      e_ready = r;
      e_valid = v;
      e_tx    = t;
      e_done  = d;
   endtask

   task automatic idle_in();
      slave_select    = 1'b0;
      master_valid    = 1'b0;
      write_en        = 1'b0;
      read_en         = 1'b0;
      rx_address      = 1'b0;
      rx_burst_number = 1'b0;
      rx_data         = 1'b0;
      master_ready    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] word_at(input int k);
      logic [7:0] w;
      w = 8'h00;
      if (rd_bits.size() >= (k + 1) * 8)
         for (int i = 0; i < 8; i++) w[i] = rd_bits[k * 8 + i];
      return w;
   endfunction

   task automatic do_write(input logic [11:0] a, input logic [11:0] b,
                           input int nw, input int astall, input int dstall,
                           input int abort_at, input int rst_at,
                           output int lat);
      int t0;
      lat = -1;
      step();
      expect_o(1, 0, 0, 0);
      slave_select = 1; master_valid = 1; write_en = 1; read_en = 0;
      rx_address = a[0]; rx_burst_number = b[0];
      t0 = cyc;
      for (int k = 1; k < 12; k++) begin
         if (k == astall) begin
            repeat (3) begin
               step();
               expect_o(0, 0, 0, 0);
               master_valid = 0;
               rx_address = ~a[k]; rx_burst_number = ~b[k];
            end
         end
         step();
         expect_o(0, 0, 0, 0);
         master_valid = 1;
         rx_address = a[k]; rx_burst_number = b[k];
      end
      for (int w = 0; w < nw; w++) begin
         for (int i = 0; i < 8; i++) begin
            if (w == 0 && i == dstall) begin
               repeat (3) begin
                  step();
                  expect_o(1, 0, 0, 0);
                  master_valid = 0;
                  rx_data = ~wq[w][i];
               end
            end
            step();
            expect_o(1, 0, 0, 0);
            master_valid = 1;
            rx_data = wq[w][i];
            if (w == 0 && i == abort_at) begin
               slave_select = 0;
               step();
               expect_o(1, 0, 0, 0);
               idle_in();
               return;
            end
            if (w == 0 && i == rst_at) begin
               #2;
               reset = 0;
               #1;
               chk("rst_ready", 32'(slave_ready), 32'd1);
               chk("rst_valid", 32'(slave_valid), 32'd0);
               chk("rst_tx", 32'(tx_data), 32'd0);
               chk("rst_done", 32'(done), 32'd0);
               step();
               idle_in();
               reset = 1;
               expect_o(1, 0, 0, 0);
               return;
            end
         end
      end
      step();
      expect_o(0, 0, 0, 1);
      idle_in();
      lat = cyc - t0;
      step();
      expect_o(1, 0, 0, 0);
      for (int w = 0; w < nw; w++) model[(int'(a[5:0]) + w) % 64] = wq[w];
   endtask

   task automatic do_read(input logic [11:0] a, input logic [11:0] b,
                          input int nw, input int rwstall, input bit mrdrop,
                          output int lat);
      int t0;
      int idx;
      step();
      expect_o(1, 0, 0, 0);
      slave_select = 1; master_valid = 1; write_en = 0; read_en = 1;
      rx_address = a[0]; rx_burst_number = b[0];
      t0 = cyc;
      for (int k = 1; k < 12; k++) begin
         step();
         expect_o(0, 0, 0, 0);
         rx_address = a[k]; rx_burst_number = b[k];
      end
      for (int w = 0; w < nw; w++) begin
         idx = (int'(a[5:0]) + w) % 64;
         if (w == 0) begin
            repeat (rwstall) begin
               step();
               expect_o(0, 0, 0, 0);
               master_valid = 0; master_ready = 0;
            end
         end
         step();
         expect_o(0, 0, 0, 0);
         master_valid = 0; master_ready = 1;
         for (int i = 0; i < 8; i++) begin
            step();
            expect_o(0, 1, model[idx][i], 0);
            master_ready = !(mrdrop && i >= 2 && i <= 4);
         end
      end
      step();
      expect_o(0, 0, 0, 1);
      idle_in();
      lat = cyc - t0;
      step();
      expect_o(1, 0, 0, 0);
   endtask

   initial begin
      int lat;
      int dc;
      reset = 0;
      idle_in();
      expect_o(1, 0, 0, 0);
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      chk_en = 1'b1;
      step();
      step();
      #3;
      chk("reset_ready", 32'(slave_ready), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
      step();
      reset = 1;

      // write_en and read_en together must not start anything
      step();
      slave_select = 1; master_valid = 1; write_en = 1; read_en = 1;
      step();
      idle_in();
      #3;
      chk("illegal_idle", 32'(slave_ready), 32'd1);

      wq[0] = 8'hA5;
      do_write(12'h005, 12'h000, 1, -1, -1, -1, -1, lat);
      chk("wr_latency", lat, 20);

      rd_bits.delete();
      do_read(12'h005, 12'h000, 1, 0, 0, lat);
      chk("rd_latency", lat, 21);
      chk("rd_valid_cycles", rd_bits.size(), 8);
      chk("rd_word", 32'(word_at(0)), 32'hA5);

      wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
      do_write(12'h03F, 12'h002, 3, -1, -1, -1, -1, lat);
      chk("burst_wr_latency", lat, 36);

      rd_bits.delete();
      do_read(12'h03F, 12'h002, 3, 0, 1, lat);
      chk("burst_rd_latency", lat, 39);
      chk("burst_w63", 32'(word_at(0)), 32'h11);
      chk("burst_w0", 32'(word_at(1)), 32'h22);
      chk("burst_w1", 32'(word_at(2)), 32'h33);

      rd_bits.delete();
      do_read(12'hFC5, 12'h000, 1, 0, 0, lat);
      chk("upper_addr_ignored", 32'(word_at(0)), 32'hA5);

      wq[0] = 8'h5C;
      do_write(12'h007, 12'h000, 1, 5, 3, -1, -1, lat);
      chk("stall_wr_latency", lat, 26);
      rd_bits.delete();
      do_read(12'h007, 12'h000, 1, 3, 0, lat);
      chk("stall_rd_latency", lat, 24);
      chk("stall_rd_word", 32'(word_at(0)), 32'h5C);

      wq[0] = 8'h3C;
      do_write(12'h00A, 12'h000, 1, -1, -1, -1, -1, lat);
      dc = done_cnt;
      wq[0] = 8'hFF;
      do_write(12'h00A, 12'h000, 1, -1, -1, 4, -1, lat);
      chk("abort_no_done", done_cnt, dc);
      rd_bits.delete();
      do_read(12'h00A, 12'h000, 1, 0, 0, lat);
      chk("abort_mem_kept", 32'(word_at(0)), 32'h3C);

      wq[0] = 8'h5A;
      do_write(12'h014, 12'h000, 1, -1, -1, -1, -1, lat);
      wq[0] = 8'h00;
      do_write(12'h014, 12'h000, 1, -1, -1, -1, 5, lat);
      rd_bits.delete();
      do_read(12'h014, 12'h000, 1, 0, 0, lat);
      chk("reset_mem_kept", 32'(word_at(0)), 32'h5A);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
